uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart to the team's uart_tx.
- Runs on the same system clock and uses the same CLOCKS_PER_BIT baud divisor.
- Synchronises the asynchronous serial line, validates the start bit at mid-bit, and samples 8 data bits LSB-first plus one stop bit.
- Presents each received byte with a one-cycle valid pulse, or a one-cycle framing-error pulse.

Parameters:
- CLOCKS_PER_BIT, 1302: system clocks per bit period (must be >= 4; 1302 gives 9600 baud at 12.5 MHz).

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_rx_serial  input  1  asynchronous serial line; idles high.
- o_rx_data  output  8  last correctly framed byte; holds its value until the next good byte.
- o_rx_data_valid  output  1  one-cycle pulse; o_rx_data is new this cycle.
- o_rx_frame_err  output  1  one-cycle pulse; stop bit sampled low.
- o_rx_active  output  1  high while a frame is being received (START through STOP).

Behaviour:
- Reset: async assert on i_rst_n low, with effect independent of i_clk.
  - o_rx_data=0, o_rx_data_valid=0, o_rx_frame_err=0, o_rx_active=0.
  - Both synchroniser flops=1; state=IDLE; counter=0; bit index=0.
  - Reset mid-frame aborts the frame with no pulse emitted.
- Synchroniser: 2 flops on i_rx_serial. All FSM decisions use the second flop (rx_s), never the raw pin.
- HALF = (CLOCKS_PER_BIT-1)/2, integer division.
- Counter width = $clog2(CLOCKS_PER_BIT). Counter never exceeds CLOCKS_PER_BIT-1.
- FSM states (3-bit encoding):
  - IDLE: counter=0, index=0, o_rx_active=0. If rx_s==0, go to START.
  - START: o_rx_active=1.
    - While counter<HALF, increment counter.
    - At counter==HALF: if rx_s==0, counter=0 and go to RECEIVE; if rx_s==1 (false start or glitch), go to IDLE with no pulse.
  - RECEIVE:
    - While counter<CLOCKS_PER_BIT-1, increment counter.
    - At CLOCKS_PER_BIT-1: shift register bit[index]=rx_s and counter=0. If index<7, index+1; else index=0 and go to STOP.
  - STOP:
    - Wait CLOCKS_PER_BIT-1 counts, then sample rx_s.
    - If rx_s==1: o_rx_data<=shift register and o_rx_data_valid<=1.
    - If rx_s==0: o_rx_frame_err<=1; o_rx_data unchanged.
    - In both cases: o_rx_active<=0, counter=0, go to CLEANUP.
  - CLEANUP:
    - Both pulses are forced back to 0, so each is exactly one cycle wide.
    - Stay in CLEANUP while rx_s==0 (break or line stuck low); go to IDLE on the first cycle rx_s==1.
    - A break therefore produces exactly one frame_err.
  - default: go to IDLE.
- Mutual exclusion: o_rx_data_valid and o_rx_frame_err are never high in the same cycle.
- Latency: the pulse asserts 3 + (HALF+1) + 9*CLOCKS_PER_BIT cycles (±1) after the falling start edge on i_rx_serial.
- Sampling: data and stop bits are sampled at bit centre ±1 cycle.
- Back-to-back frames: a start edge arriving right after the stop bit is caught. The stop-bit sample plus one CLEANUP cycle consumes about half a bit, so reception needs no idle gap.
- No input handshake or backpressure: the consumer must take o_rx_data within one frame time. A new byte overwrites the old one.

Decomposition:
- Shared include uart_defs.vh, used by both uart_tx and uart_rx:
  - state encodings (IDLE/START/DATA/STOP/CLEANUP, 3 bits);
  - default CLOCKS_PER_BIT;
  - data width 8.
- One natural sub-module, uart_rx_sync: 2-flop synchroniser, reset value 1, parameterised width.

Test Plan:
- All scenarios run with CLOCKS_PER_BIT=16, HALF=7, bit period 16 clocks.
- Send 0x55 with a correct stop bit -> one o_rx_data_valid pulse ~155 cycles after the start edge, o_rx_data=0x55, frame_err never high.
- Send 0xA3 then 0x0F back-to-back with no idle gap -> two valid pulses ~160 cycles apart; data 0xA3 then 0x0F.
- Drive i_rx_serial low for 4 clocks, then high -> FSM returns to IDLE; no valid, no frame_err; o_rx_active high for <10 cycles.
- Send 0xFF with the stop bit held low, then keep the line low for 100 clocks -> exactly one frame_err pulse; o_rx_data keeps the previous value (0x0F); no new frame starts until the line returns high.
- Assert i_rst_n=0 during bit 4 of 0x3C -> all outputs 0 immediately, with no pulse. After release, send 0xC3 -> o_rx_data=0xC3 with valid.
- Loopback: uart_tx output into uart_rx, sending bytes 0x00, 0x80, 0x01, 0xFF -> each byte received intact, one valid per o_tx_done.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Brief    : Shared UART framing constants and receiver state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  localparam int c_DATA_WIDTH               = 8;
  localparam int c_CLOCKS_PER_BIT_DEFAULT   = 1302;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Brief    : Two-flop synchroniser for asynchronous inputs; resets to 1 (idle line).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with mid-bit sampling, valid and framing-error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = c_CLOCKS_PER_BIT_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rx_serial,
  output logic [c_DATA_WIDTH-1:0] o_rx_data,
  output logic                    o_rx_data_valid,
  output logic                    o_rx_frame_err,
  output logic                    o_rx_active
);

  localparam int                 c_CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLOCKS_PER_BIT - 1);

  if (CLOCKS_PER_BIT < 4) begin : g_bad_divisor
    $error("uart_rx: CLOCKS_PER_BIT must be >= 4");
  end

  logic                    w_rx_s;
  rx_state_t               r_state;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [2:0]              r_idx;
  logic [c_DATA_WIDTH-1:0] r_shift;
  logic [c_DATA_WIDTH-1:0] r_rx_data;
  logic                    r_data_valid;
  logic                    r_frame_err;
  logic                    r_active;

  uart_rx_sync #(
    .WIDTH (1)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx_serial),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_rx_data    <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      // Pulses default low so each one is exactly one cycle wide.
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt    <= '0;
          r_idx    <= '0;
          r_active <= 1'b0;
          if (!w_rx_s) begin
            r_state  <= ST_START;
            r_active <= 1'b1;
          end
        end
        ST_START: begin
          if (r_cnt < c_HALF) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (!w_rx_s) begin
            r_cnt   <= '0;
            r_state <= ST_DATA;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (r_cnt < c_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx_s;
            if (r_idx < 3'd7) begin
              r_idx <= r_idx + 3'd1;
            end else begin
              r_idx   <= '0;
              r_state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (r_cnt < c_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            if (w_rx_s) begin
              r_rx_data    <= r_shift;
              r_data_valid <= 1'b1;
            end else begin
              r_frame_err  <= 1'b1;
            end
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ST_CLEANUP;
          end
        end
        ST_CLEANUP: begin
          // Hold here through a break so it yields a single framing error.
          if (w_rx_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_cnt    <= '0;
          r_idx    <= '0;
          r_active <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rx_data       = r_rx_data;
  assign o_rx_data_valid = r_data_valid;
  assign o_rx_frame_err  = r_frame_err;
  assign o_rx_active     = r_active;

endmodule
`default_nettype wire
